// File: rtl/line_burst_master.sv
// Memory-side initiator for the picorv32 native bus: moves one cache line as
// WORDS_PER_LINE back-to-back single-word transfers, with an optional stall watchdog.
module line_burst_master #(
  parameter int WORDS_PER_LINE = 4,
  parameter int TIMEOUT        = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic                            req_instr,
  input  logic [31:0]                     req_addr,
  input  logic [32*WORDS_PER_LINE-1:0]    req_wdata,
  output logic                            rd_valid,
  output logic [31:0]                     rd_data,
  output logic [$clog2(WORDS_PER_LINE)-1:0] rd_index,
  output logic                            done,
  output logic                            err,
  output logic                            mem_valid,
  output logic                            mem_instr,
  input  logic                            mem_ready,
  output logic [31:0]                     mem_addr,
  output logic [31:0]                     mem_wdata,
  output logic [3:0]                      mem_wstrb,
  input  logic [31:0]                     mem_rdata
);

  localparam int IW = $clog2(WORDS_PER_LINE);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0]   OFF_MASK = 32'(WORDS_PER_LINE * 4 - 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [31:0]                 base_q, base_d;
  logic                        write_q, write_d;
  logic [32*WORDS_PER_LINE-1:0] line_q, line_d;
  logic [IW-1:0]               idx_q, idx_d, idx_nx;
  logic [WW-1:0]               wait_q, wait_d;

  logic                        mem_valid_q, mem_valid_d;
  logic                        mem_instr_q, mem_instr_d;
  logic [31:0]                 mem_addr_q, mem_addr_d;
  logic [31:0]                 mem_wdata_q, mem_wdata_d;
  logic [3:0]                  mem_wstrb_q, mem_wstrb_d;
  logic                        rd_valid_q, rd_valid_d;
  logic [31:0]                 rd_data_q, rd_data_d;
  logic [IW-1:0]               rd_index_q, rd_index_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        hs;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    write_d     = write_q;
    line_d      = line_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    mem_valid_d = mem_valid_q;
    mem_instr_d = mem_instr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    rd_index_d  = rd_index_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    hs          = mem_valid_q && mem_ready;
    idx_nx      = idx_q + IW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          base_d      = req_addr & ~OFF_MASK;
          write_d     = req_write;
          line_d      = req_wdata;
          idx_d       = '0;
          wait_d      = '0;
          mem_valid_d = 1'b1;
          mem_instr_d = req_instr;
          mem_addr_d  = req_addr & ~OFF_MASK;
          mem_wdata_d = req_write ? req_wdata[31:0] : '0;
          mem_wstrb_d = req_write ? 4'hF : 4'h0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A handshake on the watchdog's final cycle still counts as progress.
        if (hs) begin
          wait_d = '0;
          if (!write_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_rdata;
            rd_index_d = idx_q;
          end
          if (idx_q == LAST_IDX) begin
            mem_valid_d = 1'b0;
            mem_wstrb_d = 4'h0;
            done_d      = 1'b1;
            state_d     = S_DONE;
          end else begin
            idx_d       = idx_nx;
            mem_addr_d  = base_q + 32'({idx_nx, 2'b00});
            mem_wdata_d = write_q ? line_q[32*idx_nx +: 32] : '0;
          end
        end else if (TIMEOUT != 0 && wait_q == WAIT_LIM) begin
          mem_valid_d = 1'b0;
          mem_wstrb_d = 4'h0;
          done_d      = 1'b1;
          err_d       = 1'b1;
          state_d     = S_DONE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      write_q     <= 1'b0;
      line_q      <= '0;
      idx_q       <= '0;
      wait_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_index_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      write_q     <= write_d;
      line_q      <= line_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      mem_valid_q <= mem_valid_d;
      mem_instr_q <= mem_instr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_index_q  <= rd_index_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign mem_valid = mem_valid_q;
  assign mem_instr = mem_instr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_index  = rd_index_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_line_burst_master.sv
// Bench for line_burst_master: directed burst table, reset/back-to-back sequences,
// and random bursts against a line-level memory model with a latency-configurable responder.
module tb_line_burst_master;
  localparam int WPL = 4;
  localparam int TO  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready, req_write, req_instr;
  logic [31:0]      req_addr;
  logic [32*WPL-1:0] req_wdata;
  logic             rd_valid;
  logic [31:0]      rd_data;
  logic [1:0]       rd_index;
  logic             done, err;
  logic             mem_valid, mem_instr, mem_ready;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  logic [3:0]       mem_wstrb;

  line_burst_master #(.WORDS_PER_LINE(WPL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_instr(req_instr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_index(rd_index), .done(done), .err(err),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC3D2E1F0;
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        ins;
    int          c;
  } hs_t;
  typedef struct {
    int          idx;
    logic [31:0] d;
  } rd_t;
  typedef struct {
    logic              w;
    logic              ins;
    logic [31:0]       addr;
    logic [32*WPL-1:0] wd;
    int                mode;     // 0: fixed delay dly per word, 1: random 0..4 per word
    int                dly;
    logic [31:0]       exp_base;
    logic              exp_err;
    int                exp_lat;  // done cycle minus accept cycle, -1 = unchecked
    int                exp_vcyc; // total mem_valid cycles, -1 = unchecked
  } vec_t;

  hs_t        hs_q[$];
  rd_t        rd_q[$];
  logic       dn_err[$];
  int         dn_cyc[$];
  logic       dn_mv[$];
  logic [3:0] dn_ws[$];
  bit         rr_log[int];
  int         vcyc = 0, stab_err = 0;

  int   rmode = 0, rdelay = 0, cur_d = 0, wcnt = 0;
  bit   last_v = 1'b0;
  logic pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [31:0] pa = '0, pd = '0;
  logic [3:0]  ps = '0;

  function automatic int pick_d();
    return (rmode == 1) ? int'($urandom_range(0, 4)) : rdelay;
  endfunction

  // Memory responder and bus monitor, both acting on the falling edge.
  always @(negedge clk) begin
    if (last_v && mem_ready) begin
      wcnt  = 0;
      cur_d = pick_d();
    end
    if (!mem_valid) wcnt = 0;
    mem_ready = mem_valid && (wcnt >= cur_d);
    mem_rdata = mem_ready ? memf(mem_addr) : $urandom;
    if (mem_valid && !mem_ready) wcnt++;
    last_v = mem_valid;
    rr_log[cyc] = req_ready;
    if (rd_valid) rd_q.push_back('{int'(rd_index), rd_data});
    if (done) begin
      dn_err.push_back(err);
      dn_cyc.push_back(cyc);
      dn_mv.push_back(mem_valid);
      dn_ws.push_back(mem_wstrb);
    end
    if (!reset) begin
      if (mem_valid) vcyc++;
      if (mem_valid && mem_ready) hs_q.push_back('{mem_addr, mem_wdata, mem_wstrb, mem_instr, cyc});
      if (pv && !pr && !prst && mem_valid &&
          (mem_addr !== pa || mem_wdata !== pd || mem_wstrb !== ps)) stab_err++;
    end
    pv = mem_valid; pr = mem_ready; pa = mem_addr; pd = mem_wdata; ps = mem_wstrb; prst = reset;
  end

  task automatic clear_logs();
    hs_q.delete(); rd_q.delete(); dn_err.delete(); dn_cyc.delete(); dn_mv.delete(); dn_ws.delete();
    vcyc = 0; stab_err = 0;
  endtask

  task automatic set_mem(input int mode, input int dly);
    rmode = mode; rdelay = dly; cur_d = pick_d(); wcnt = 0;
  endtask

  task automatic start_req(input logic w, input logic ins, input logic [31:0] a,
                           input logic [32*WPL-1:0] wd, output int t0);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (req_ready) break;
    end
    chk("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_instr = ins; req_addr = a; req_wdata = wd;
    t0 = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = ~w; req_instr = ~ins; req_addr = $urandom;
    for (int k = 0; k < WPL; k++) req_wdata[32*k +: 32] = $urandom;
    chk("busy_ready", 32'(req_ready), 32'd0);
  endtask

  task automatic wait_done(input int n);
    for (int k = 0; k < 400; k++) begin
      if (dn_cyc.size() >= n) break;
      @(posedge clk); #1;
    end
    chk("done_count", 32'(dn_cyc.size()), 32'(n));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_burst(input vec_t v, input int t0);
    int nw, nrd;
    nw  = v.exp_err ? 0 : WPL;
    nrd = (!v.w && !v.exp_err) ? WPL : 0;
    chk("hs_count", 32'(hs_q.size()), 32'(nw));
    for (int i = 0; i < nw && i < hs_q.size(); i++) begin
      chk($sformatf("addr%0d", i), hs_q[i].a, v.exp_base + 32'(4 * i));
      chk($sformatf("wdata%0d", i), hs_q[i].d, v.w ? v.wd[32*i +: 32] : 32'h0);
      chk($sformatf("strb_instr%0d", i), {27'b0, hs_q[i].s, hs_q[i].ins},
          {27'b0, (v.w ? 4'hF : 4'h0), v.ins});
    end
    chk("rd_count", 32'(rd_q.size()), 32'(nrd));
    for (int i = 0; i < nrd && i < rd_q.size(); i++) begin
      chk($sformatf("rd_index%0d", i), 32'(rd_q[i].idx), 32'(i));
      chk($sformatf("rd_data%0d", i), rd_q[i].d, memf(v.exp_base + 32'(4 * i)));
    end
    if (dn_cyc.size() > 0) begin
      chk("err", 32'(dn_err[0]), 32'(v.exp_err));
      chk("done_mem_valid", 32'(dn_mv[0]), 32'd0);
      chk("done_wstrb", 32'(dn_ws[0]), 32'd0);
      chk("done_ready", 32'(rr_log[dn_cyc[0]]), 32'd0);
      chk("ready_after", 32'(rr_log[dn_cyc[0] + 1]), 32'd1);
      if (v.exp_lat >= 0) chk("latency", 32'(dn_cyc[0] - t0), 32'(v.exp_lat));
    end
    if (v.exp_vcyc >= 0) chk("valid_cycles", 32'(vcyc), 32'(v.exp_vcyc));
    chk("stable", 32'(stab_err), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int t0;
    clear_logs();
    set_mem(v.mode, v.dly);
    start_req(v.w, v.ins, v.addr, v.wd, t0);
    wait_done(1);
    check_burst(v, t0);
  endtask

  vec_t tbl[7];

  initial begin
    vec_t v;
    int   t0, d;

    tbl[0] = '{w:1'b0, ins:1'b0, addr:32'h0000_1000, wd:'0, mode:0, dly:0,
               exp_base:32'h0000_1000, exp_err:1'b0, exp_lat:5, exp_vcyc:4};
    tbl[1] = '{w:1'b0, ins:1'b1, addr:32'h0000_100C, wd:'0, mode:0, dly:2,
               exp_base:32'h0000_1000, exp_err:1'b0, exp_lat:13, exp_vcyc:12};
    tbl[2] = '{w:1'b1, ins:1'b0, addr:32'h0000_2000,
               wd:{32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA}, mode:0, dly:0,
               exp_base:32'h0000_2000, exp_err:1'b0, exp_lat:5, exp_vcyc:4};
    tbl[3] = '{w:1'b0, ins:1'b0, addr:32'h0000_3000, wd:'0, mode:0, dly:1000,
               exp_base:32'h0000_3000, exp_err:1'b1, exp_lat:9, exp_vcyc:8};
    tbl[4] = '{w:1'b1, ins:1'b1, addr:32'hFFFF_FFF7,
               wd:{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, mode:0, dly:1,
               exp_base:32'hFFFF_FFF0, exp_err:1'b0, exp_lat:9, exp_vcyc:8};
    tbl[5] = '{w:1'b0, ins:1'b0, addr:32'h0000_0044, wd:'0, mode:0, dly:7,
               exp_base:32'h0000_0040, exp_err:1'b0, exp_lat:33, exp_vcyc:32};
    tbl[6] = '{w:1'b1, ins:1'b0, addr:32'h0000_0080,
               wd:{32'h0BAD_F00D, 32'hCAFE_BABE, 32'h1234_5678, 32'h8765_4321}, mode:0, dly:8,
               exp_base:32'h0000_0080, exp_err:1'b1, exp_lat:9, exp_vcyc:8};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_instr = 1'b0;
    req_addr = '0; req_wdata = '0;
    set_mem(0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_wstrb_instr", {27'b0, mem_wstrb, mem_instr}, 32'd0);
    chk("rst_rd", {29'b0, rd_valid, rd_index}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_done_err", {30'b0, done, err}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Reset while word 2 of a read is on the bus.
    clear_logs();
    set_mem(0, 0);
    start_req(1'b0, 1'b0, 32'h0000_5000, '0, t0);
    for (int k = 0; k < 10; k++) begin
      if (mem_valid && mem_addr == 32'h0000_5008) break;
      @(posedge clk); #1;
    end
    chk("word2_reached", mem_addr, 32'h0000_5008);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_valid", 32'(mem_valid), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_rd_done", {30'b0, rd_valid, done}, 32'd0);
    chk("mid_rst_wstrb", 32'(mem_wstrb), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("mid_rst_no_done", 32'(dn_cyc.size()), 32'd0);
    chk("mid_rst_rd_count", 32'(rd_q.size()), 32'd2);
    chk("mid_rst_hs_count", 32'(hs_q.size()), 32'd2);
    v = '{w:1'b0, ins:1'b1, addr:32'h0000_5004, wd:'0, mode:0, dly:0,
          exp_base:32'h0000_5000, exp_err:1'b0, exp_lat:5, exp_vcyc:4};
    run_vec(v);

    // Two requests with req_valid held high across the first burst.
    clear_logs();
    set_mem(0, 0);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (req_ready) break;
    end
    req_valid = 1'b1; req_write = 1'b0; req_instr = 1'b0; req_addr = 32'h0000_6000;
    @(posedge clk); #1;
    req_addr = 32'h0000_7000;
    for (int k = 0; k < 60; k++) begin
      if (hs_q.size() >= 5) break;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    wait_done(2);
    chk("b2b_hs_count", 32'(hs_q.size()), 32'd8);
    chk("b2b_rd_count", 32'(rd_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < hs_q.size(); i++)
      chk($sformatf("b2b_addr%0d", i), hs_q[i].a,
          (i < 4) ? 32'h0000_6000 + 32'(4 * i) : 32'h0000_7000 + 32'(4 * (i - 4)));
    if (hs_q.size() >= 5 && dn_cyc.size() >= 1) begin
      chk("b2b_first_end", 32'(hs_q[3].c < dn_cyc[0]), 32'd1);
      chk("b2b_second_start", 32'(hs_q[4].c), 32'(dn_cyc[0] + 2));
    end

    // Random bursts against the line-level model.
    for (int n = 0; n < 40; n++) begin
      v.w    = 1'($urandom);
      v.ins  = 1'($urandom);
      v.addr = $urandom;
      for (int k = 0; k < WPL; k++) v.wd[32*k +: 32] = $urandom;
      v.exp_base = (v.addr / (4 * WPL)) * (4 * WPL);
      v.mode = int'($urandom_range(0, 1));
      if (v.mode == 0) begin
        d = int'($urandom_range(0, 9));
        v.dly      = d;
        v.exp_err  = (d + 1 > TO);
        v.exp_lat  = v.exp_err ? TO + 1 : WPL * (d + 1) + 1;
        v.exp_vcyc = v.exp_err ? TO : WPL * (d + 1);
      end else begin
        v.dly      = 0;
        v.exp_err  = 1'b0;
        v.exp_lat  = -1;
        v.exp_vcyc = -1;
      end
      run_vec(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/line_burst_master.md
Name: line_burst_master

Overview:
- Memory-side initiator of the picorv32 native memory interface (valid/ready/addr/wdata/wstrb/rdata).
- Takes one whole-line request from a cache controller, either a refill read or a writeback write.
- Issues the line as WORDS_PER_LINE sequential single-word transactions to the memory module.
- Returns read words as a stream, ends each burst with a done/err pulse, and sits between the cache tag/data logic and memory.

Parameters:
- WORDS_PER_LINE, 4: 32-bit words per line; power of two, 2..16.
- TIMEOUT, 64: consecutive mem_valid cycles without mem_ready before the burst aborts; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  line request present.
- req_ready  out  1  block idle, can accept a request.
- req_write  in  1  1 = writeback, 0 = refill.
- req_instr  in  1  forwarded to mem_instr for the whole burst.
- req_addr  in  32  byte address; the low log2(WORDS_PER_LINE)+2 bits are ignored.
- req_wdata  in  32*WORDS_PER_LINE  writeback line; word i is bits [32i+31:32i].
- rd_valid  out  1  one read word available this cycle.
- rd_data  out  32  read word.
- rd_index  out  log2(WORDS_PER_LINE)  word index within the line.
- done  out  1  one-cycle pulse when a burst ends.
- err  out  1  valid with done; 1 = timeout abort.
- mem_valid  out  1  transaction request.
- mem_instr  out  1  instruction-fetch flag.
- mem_ready  in  1  memory completes the transaction this cycle.
- mem_addr  out  32  word-aligned address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  byte strobes; 4'hF for a write, 4'h0 for a read.
- mem_rdata  in  32  read data, valid when mem_ready=1.

Behaviour:
- Reset values: req_ready=1 (IDLE); mem_valid=0; mem_addr=0; mem_wdata=0; mem_wstrb=0; mem_instr=0; rd_valid=0; rd_data=0; rd_index=0; done=0; err=0; word and wait counters cleared.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge: latch base = req_addr with the line-offset bits zeroed, plus req_write, req_instr and req_wdata (the requester may change its inputs afterwards).
  - Set word counter i=0 and go to ISSUE.
- ISSUE:
  - Outputs are registered and held stable until the handshake: mem_valid=1, mem_addr=base+4*i, mem_instr and mem_wstrb as latched, mem_wdata=word i (or 0 for a read).
  - Handshake = mem_valid && mem_ready sampled at an edge.
  - On a read handshake, the next cycle gives rd_valid=1, rd_data=mem_rdata, rd_index=i. rd_valid is a one-cycle pulse with no backpressure; the consumer must take it.
  - After handshake i < WORDS_PER_LINE-1: the next cycle presents word i+1 with mem_valid held at 1 (back-to-back, no idle cycle).
  - After the last handshake: mem_valid=0 and go to DONE.
- Watchdog (TIMEOUT>0):
  - The wait counter increments each ISSUE cycle without mem_ready and clears on every handshake.
  - When it reaches TIMEOUT: mem_valid=0, mem_wstrb=0, no further words, go to DONE with err=1.
  - A handshake in the same cycle as the limit takes priority and the burst continues normally.
- DONE: for exactly one cycle, done=1, with err=1 only for a timeout abort; then IDLE. req_ready is 0 in ISSUE and DONE.
- Latency with mem_ready tied high:
  - Request accepted at edge T.
  - Words issued in cycles T+1..T+WPL.
  - rd_valid in cycles T+2..T+WPL+1.
  - done in cycle T+WPL+1.
  - req_ready=1 again in cycle T+WPL+2.
- Address arithmetic: the burst never crosses the line; the address wraps within 32 bits (base 0xFFFFFFF0 gives words up to 0xFFFFFFFC).
- Reset mid-burst: all outputs return to reset values at the next edge, with no done pulse and no rd_valid. The in-flight memory transaction is abandoned; memory must tolerate mem_valid dropping.
- req_valid while busy is ignored (not queued).

Test Plan:
- Read, WPL=4, req_addr=0x0000_1000, mem_ready always 1 -> mem_addr 0x1000, 0x1004, 0x1008, 0x100C in consecutive cycles; rd_index 0..3 with the matching rdata; done=1, err=0 at T+5; req_ready=1 at T+6.
- Read, req_addr=0x0000_100C (unaligned), memory with mem_ready 2 cycles after each valid -> base is 0x1000; each address holds 3 cycles; rd_data matches memory; done at T+13.
- Write, req_wdata={0xDDDDDDDD,0xCCCCCCCC,0xBBBBBBBB,0xAAAAAAAA}, req_wdata changed the cycle after accept -> mem_wdata AAAA.., BBBB.., CCCC.., DDDD.. on 0x2000..0x200C; mem_wstrb=4'hF; no rd_valid.
- TIMEOUT=8, mem_ready held 0 -> mem_valid high exactly 8 cycles on word 0; then done=1, err=1; rd_valid never asserts; req_ready returns.
- reset=1 during word 2 of a read -> next edge gives mem_valid=0, req_ready=1, no done pulse; a fresh request afterwards completes normally from word 0.
- Two back-to-back requests with req_valid held high -> the second is accepted in the first IDLE cycle after done; no word overlap between bursts.
